// File: rtl/vline_motion_ctrl_if.sv
// Handshake bundle between the motion controller and its environment.
// slave = controller side, master = driver of buttons/frame/counter flags.
interface vline_motion_ctrl_if;
  logic        frame;
  logic        btn_u;
  logic        btn_d;
  logic        btn_c;
  logic        recentre;
  logic        at_max;
  logic        at_min;
  logic        up;
  logic        dw;
  logic        ld;
  logic [15:0] d;
  logic        moving;
  logic        dir;

  modport slave (
    input  frame, btn_u, btn_d, btn_c, recentre, at_max, at_min,
    output up, dw, ld, d, moving, dir
  );

  modport master (
    output frame, btn_u, btn_d, btn_c, recentre, at_max, at_min,
    input  up, dw, ld, d, moving, dir
  );
endinterface

// File: rtl/vline_motion_ctrl.sv
// Vertical-line motion controller: buttons + frame tick -> UP/DW/LD strobes for the Y counter.
// Optional AUTO_BOUNCE_EN: reverse direction on a bound hit instead of stopping.
module vline_motion_ctrl #(
  parameter int unsigned STEP_DIV = 2,
  parameter logic [15:0] LOAD_VAL = 16'd240
) (
  input logic               clk,
  input logic               reset,
  vline_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StLoad, StIdle, StRunInc, StRunDec} state_e;

  localparam logic [7:0] DivLast = 8'(STEP_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic       up_q, up_d;
  logic       dw_q, dw_d;
  logic       ld_q, ld_d;
  logic       dir_q, dir_d;
  logic       moving_q, moving_d;

  // Button bits ordered {c, d, u}; s1/s2 synchronise, s3 holds the previous level.
  logic [2:0] btn_s1_q, btn_s2_q, btn_s3_q;
  logic [2:0] press;
  logic       press_u, press_d, press_c;
  logic       run_up;
  logic       hit;

  assign press   = btn_s2_q & ~btn_s3_q;
  assign press_u = press[0];
  assign press_d = press[1];
  assign press_c = press[2];
  assign run_up  = (state_q == StRunInc);
  assign hit     = run_up ? bus.at_max : bus.at_min;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    dir_d   = dir_q;
    up_d    = 1'b0;
    dw_d    = 1'b0;
    ld_d    = 1'b0;

    if (bus.recentre) begin
      state_d = StLoad;
      ld_d    = 1'b1;
      div_d   = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          state_d = StIdle;
          ld_d    = 1'b1;
          div_d   = '0;
        end
        StIdle: begin
          div_d = '0;
          if (!press_c && (press_u ^ press_d)) begin
            state_d = press_u ? StRunInc : StRunDec;
            dir_d   = press_u;
          end
        end
        StRunInc, StRunDec: begin
          if (press_c) begin
            state_d = StIdle;
            div_d   = '0;
          end else if ((press_u ^ press_d) && (press_u != run_up)) begin
            // Opposite-direction press: reverse and restart the frame count
            state_d = press_u ? StRunInc : StRunDec;
            dir_d   = press_u;
            div_d   = '0;
          end else if (bus.frame) begin
            if (div_q == DivLast) begin
              div_d = '0;
              if (bus.at_max && bus.at_min) begin
                state_d = StIdle;
              end else if (hit) begin
`ifdef AUTO_BOUNCE_EN
                state_d = run_up ? StRunDec : StRunInc;
                dir_d   = ~run_up;
`else
                state_d = StIdle;
`endif
              end else begin
                up_d = run_up;
                dw_d = ~run_up;
              end
            end else begin
              div_d = div_q + 8'd1;
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end

    moving_d = (state_d == StRunInc) || (state_d == StRunDec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StLoad;
      div_q    <= '0;
      up_q     <= 1'b0;
      dw_q     <= 1'b0;
      ld_q     <= 1'b0;
      dir_q    <= 1'b1;
      moving_q <= 1'b0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      btn_s3_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      up_q     <= up_d;
      dw_q     <= dw_d;
      ld_q     <= ld_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      btn_s1_q <= {bus.btn_c, bus.btn_d, bus.btn_u};
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
    end
  end

  assign bus.up     = up_q;
  assign bus.dw     = dw_q;
  assign bus.ld     = ld_q;
  assign bus.d      = LOAD_VAL;
  assign bus.moving = moving_q;
  assign bus.dir    = dir_q;

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Bench for vline_motion_ctrl: directed scenarios then random stimulus, all checked
// every cycle against a behavioural model of the controller.
module tb_vline_motion_ctrl;

  localparam int unsigned StepDiv = 2;
  localparam logic [15:0] LoadVal = 16'd240;
`ifdef AUTO_BOUNCE_EN
  localparam bit Bounce = 1'b1;
`else
  localparam bit Bounce = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  vline_motion_ctrl_if bus ();

  vline_motion_ctrl #(
    .STEP_DIV(StepDiv),
    .LOAD_VAL(LoadVal)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int up_cnt, dw_cnt, ld_cnt;

  bit in_u, in_d, in_c, in_rc, in_max, in_min;

  // Model: motion described as "loading / moving / direction / frames seen since last step"
  bit m_loading, m_moving, m_dir;
  int m_frames;
  bit [2:0] hu, hd, hc;  // button levels seen at the last three edges, [0] newest
  bit e_up, e_dw, e_ld;

  function automatic void model_reset();
    m_loading = 1'b1;
    m_moving  = 1'b0;
    m_dir     = 1'b1;
    m_frames  = 0;
    hu = '0; hd = '0; hc = '0;
    e_up = 1'b0; e_dw = 1'b0; e_ld = 1'b0;
  endfunction

  function automatic void model_edge();
    bit pu, pd, pc, bound;
    if (!reset) begin
      model_reset();
      return;
    end
    pu = hu[1] && !hu[2];
    pd = hd[1] && !hd[2];
    pc = hc[1] && !hc[2];
    hu = {hu[1:0], in_u};
    hd = {hd[1:0], in_d};
    hc = {hc[1:0], in_c};
    e_up = 1'b0; e_dw = 1'b0; e_ld = 1'b0;
    if (in_rc) begin
      m_loading = 1'b1; m_moving = 1'b0; m_frames = 0; e_ld = 1'b1;
    end else if (m_loading) begin
      m_loading = 1'b0; e_ld = 1'b1;
    end else if (!m_moving) begin
      if (!pc && (pu != pd)) begin
        m_moving = 1'b1; m_dir = pu; m_frames = 0;
      end
    end else if (pc) begin
      m_moving = 1'b0; m_frames = 0;
    end else if ((pu != pd) && (pu != m_dir)) begin
      m_dir = pu; m_frames = 0;
    end else if (bus.frame) begin
      m_frames++;
      if (m_frames == int'(StepDiv)) begin
        m_frames = 0;
        bound = m_dir ? in_max : in_min;
        if (in_max && in_min) m_moving = 1'b0;
        else if (bound) begin
          if (Bounce) m_dir = !m_dir;
          else m_moving = 1'b0;
        end else begin
          e_up = m_dir; e_dw = !m_dir;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("up", 16'(bus.up), 16'(e_up));
    chk("dw", 16'(bus.dw), 16'(e_dw));
    chk("ld", 16'(bus.ld), 16'(e_ld));
    chk("moving", 16'(bus.moving), 16'(m_moving));
    chk("dir", 16'(bus.dir), 16'(m_dir));
    chk("d", bus.d, LoadVal);
  endtask

  task automatic tick(input bit f);
    bus.frame    = f;
    bus.btn_u    = in_u;
    bus.btn_d    = in_d;
    bus.btn_c    = in_c;
    bus.recentre = in_rc;
    bus.at_max   = in_max;
    bus.at_min   = in_min;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    if (bus.up) up_cnt++;
    if (bus.dw) dw_cnt++;
    if (bus.ld) ld_cnt++;
  endtask

  task automatic press_u();
    in_u = 1'b1; repeat (3) tick(1'b0);
    in_u = 1'b0; tick(1'b0);
  endtask

  initial begin
    bit got;
    {in_u, in_d, in_c, in_rc, in_max, in_min} = '0;
    model_reset();
    up_cnt = 0; dw_cnt = 0; ld_cnt = 0;

    // Reset and load sequence
    repeat (5) tick(1'b0);
    reset = 1'b1;
    ld_cnt = 0; up_cnt = 0; dw_cnt = 0;
    repeat (4) tick(1'b0);
    chk("t1_ld_pulses", 16'(ld_cnt), 16'd1);
    chk("t1_strobes", 16'(up_cnt + dw_cnt), 16'd0);

    // Six frames at STEP_DIV=2 -> three UP strobes
    press_u();
    up_cnt = 0; dw_cnt = 0;
    repeat (6) begin tick(1'b1); tick(1'b0); end
    chk("t2_up_pulses", 16'(up_cnt), 16'd3);
    chk("t2_dw_pulses", 16'(dw_cnt), 16'd0);

    // Upper bound hit
    in_max = 1'b1; up_cnt = 0; dw_cnt = 0;
    repeat (2) begin tick(1'b1); tick(1'b0); end
    chk("t3_no_up", 16'(up_cnt), 16'd0);
    in_max = 1'b0;
    repeat (2) begin tick(1'b1); tick(1'b0); end
    chk("t3_dw_after", 16'(dw_cnt), Bounce ? 16'd1 : 16'd0);
    chk("t3_moving", 16'(bus.moving), Bounce ? 16'd1 : 16'd0);

    // C press coinciding with a due frame in RUN_DEC
    in_d = 1'b1; repeat (3) tick(1'b0);
    in_d = 1'b0; tick(1'b0);
    tick(1'b1);
    dw_cnt = 0;
    in_c = 1'b1; tick(1'b0); tick(1'b0); tick(1'b1);
    in_c = 1'b0; tick(1'b0);
    chk("t4_no_dw", 16'(dw_cnt), 16'd0);
    chk("t4_stopped", 16'(bus.moving), 16'd0);
    in_u = 1'b1; in_d = 1'b1; repeat (4) tick(1'b1);
    in_u = 1'b0; in_d = 1'b0; repeat (4) tick(1'b1);
    chk("t4_ud_ignored", 16'(bus.moving), 16'd0);

    // Recentre while moving
    press_u();
    chk("t5_running", 16'(bus.moving), 16'd1);
    in_rc = 1'b1; ld_cnt = 0; up_cnt = 0;
    repeat (3) tick(1'b1);
    in_rc = 1'b0; tick(1'b0); tick(1'b0);
    chk("t5_ld_cycles", 16'(ld_cnt), 16'd4);
    chk("t5_no_up", 16'(up_cnt), 16'd0);
    chk("t5_idle", 16'(bus.moving), 16'd0);

    // Asynchronous reset during an UP strobe
    press_u();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(i % 2 == 0);
      if (bus.up) got = 1'b1;
    end
    chk("t6_up_seen", 16'(got), 16'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("t6_async_up", 16'(bus.up), 16'd0);
    check_all();
    ld_cnt = 0;
    repeat (3) tick(1'b0);
    reset = 1'b1;
    repeat (3) tick(1'b0);
    chk("t6_ld_pulses", 16'(ld_cnt), 16'd1);

    // Random traffic
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) in_u = ~in_u;
      if ($urandom_range(0, 5) == 0) in_d = ~in_d;
      if ($urandom_range(0, 9) == 0) in_c = ~in_c;
      in_rc  = ($urandom_range(0, 49) == 0);
      in_max = ($urandom_range(0, 3) == 0);
      in_min = ($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
